// File: rtl/ad7606_ctrl.sv
// AD7606 parallel-interface controller: periodic CONVST, BUSY handshake and
// eight-channel RD/CS readout, with a timeout guard on each busy-wait state.
module ad7606_ctrl #(
  parameter int         SAMPLE_DIV   = 5000,
  parameter int         BUSY_TIMEOUT = 250,
  parameter logic [2:0] OS_RATIO     = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        busy_i,
  input  logic [15:0] data_i,
  output logic        ad_reset_o,
  output logic        ad_conv_o,
  output logic        ad_rd_o,
  output logic        ad_cs_o,
  output logic [2:0]  ad_os_o,
  output logic [15:0] ch_data_o,
  output logic [2:0]  ch_idx_o,
  output logic        ch_valid_o,
  output logic        frame_done_o,
  output logic        timeout_err_o
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int OW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] DIV_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [OW-1:0] TO_LAST  = OW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    AD_RST, IDLE, CONV, WAIT_BH, WAIT_BL, RD_LO, RD_HI
  } state_t;

  state_t        state, state_n;
  logic [1:0]    ph, ph_n;
  logic [2:0]    ch_cnt, ch_cnt_n;
  logic [TW-1:0] timer, timer_n;
  logic [OW-1:0] to_bh, to_bh_n, to_bl, to_bl_n;
  logic [15:0]   ch_data_q, ch_data_n;
  logic [2:0]    ch_idx_q, ch_idx_n;
  logic          valid_q, valid_n, done_q, done_n, terr_q, terr_n;
  logic          busy_meta, busy_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= AD_RST;
      ph        <= '0;
      ch_cnt    <= '0;
      timer     <= '0;
      to_bh     <= '0;
      to_bl     <= '0;
      ch_data_q <= '0;
      ch_idx_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      terr_q    <= 1'b0;
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      state     <= state_n;
      ph        <= ph_n;
      ch_cnt    <= ch_cnt_n;
      timer     <= timer_n;
      to_bh     <= to_bh_n;
      to_bl     <= to_bl_n;
      ch_data_q <= ch_data_n;
      ch_idx_q  <= ch_idx_n;
      valid_q   <= valid_n;
      done_q    <= done_n;
      terr_q    <= terr_n;
      busy_meta <= busy_i;
      busy_s    <= busy_meta;
    end
  end

  // The sample timer free-runs in every state so the conversion rate never
  // drifts; an expiry seen outside IDLE is simply dropped.
  always_comb begin
    state_n   = state;
    ph_n      = ph;
    ch_cnt_n  = ch_cnt;
    to_bh_n   = to_bh;
    to_bl_n   = to_bl;
    ch_data_n = ch_data_q;
    ch_idx_n  = ch_idx_q;
    valid_n   = 1'b0;
    done_n    = 1'b0;
    terr_n    = 1'b0;

    if (!enable_i || timer == DIV_LAST) timer_n = '0;
    else                                timer_n = timer + 1'b1;

    case (state)
      AD_RST: begin
        ph_n = ph + 2'd1;
        if (ph == 2'd3) begin
          state_n = IDLE;
          ph_n    = '0;
        end
      end
      IDLE: begin
        if (enable_i && timer == DIV_LAST) begin
          state_n = CONV;
          ph_n    = '0;
        end
      end
      CONV: begin
        ph_n = ph + 2'd1;
        if (ph == 2'd1) begin
          state_n = WAIT_BH;
          ph_n    = '0;
          to_bh_n = '0;
        end
      end
      WAIT_BH: begin
        if (busy_s) begin
          state_n = WAIT_BL;
          to_bl_n = '0;
        end else if (to_bh == TO_LAST) begin
          state_n = IDLE;
          terr_n  = 1'b1;
        end else begin
          to_bh_n = to_bh + 1'b1;
        end
      end
      WAIT_BL: begin
        if (!busy_s) begin
          state_n  = RD_LO;
          ph_n     = '0;
          ch_cnt_n = '0;
        end else if (to_bl == TO_LAST) begin
          state_n = IDLE;
          terr_n  = 1'b1;
        end else begin
          to_bl_n = to_bl + 1'b1;
        end
      end
      RD_LO: begin
        ph_n = ph + 2'd1;
        if (ph == 2'd1) begin
          ch_data_n = data_i;
          ch_idx_n  = ch_cnt;
          valid_n   = 1'b1;
          done_n    = (ch_cnt == 3'd7);
          state_n   = RD_HI;
          ph_n      = '0;
        end
      end
      RD_HI: begin
        ph_n = ph + 2'd1;
        if (ph == 2'd1) begin
          ph_n = '0;
          if (ch_cnt == 3'd7) begin
            state_n = IDLE;
          end else begin
            ch_cnt_n = ch_cnt + 3'd1;
            state_n  = RD_LO;
          end
        end
      end
      default: begin
        state_n = AD_RST;
        ph_n    = '0;
      end
    endcase
  end

  // Strobes are forced to their idle levels combinationally while rst is held.
  assign ad_reset_o    = rst | (state == AD_RST);
  assign ad_conv_o     = rst | (state != CONV);
  assign ad_rd_o       = rst | (state != RD_LO);
  assign ad_cs_o       = ad_rd_o;
  assign ad_os_o       = OS_RATIO;
  assign ch_data_o     = ch_data_q;
  assign ch_idx_o      = ch_idx_q;
  assign ch_valid_o    = valid_q & ~rst;
  assign frame_done_o  = done_q & ~rst;
  assign timeout_err_o = terr_q & ~rst;

endmodule
